// File: rtl/sc_io_bcd_display.sv
// Two-channel binary-to-BCD seven-segment display driver for the data-memory I/O ports.
// Channels are converted one at a time by a shared double-dabble engine.
module sc_io_bcd_display #(
  parameter int unsigned SAT_MAX    = 999,
  parameter bit          BLANK_LEAD = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy
);

  localparam logic [31:0] SAT_W   = SAT_MAX;
  localparam logic [9:0]  SAT_BIN = SAT_W[9:0];

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] snap0, snap1;
  logic        pend0, pend1;
  logic [3:0]  cnt;
  logic [9:0]  bin;
  logic [11:0] bcd;
  logic        sel;
  logic        last;
  logic [3:0]  dig [6];

  logic        load;
  logic        pick;
  logic        chg0, chg1;
  logic [31:0] load_src;
  logic [11:0] bcd_adj;
  logic [21:0] shifted;

  assign chg0 = (out_port0 != snap0);
  assign chg1 = (out_port1 != snap1);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    pick       = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          load       = 1'b1;
          pick       = (pend0 && pend1) ? ~last : pend1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 4'd9) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load_src = pick ? snap1 : snap0;

  // Add-3 correction on each nibble precedes the shift, as in classic double dabble.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin} << 1;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snap0 <= '0;
      snap1 <= '0;
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
      sel   <= 1'b0;
      last  <= 1'b1;
      for (int unsigned i = 0; i < 6; i++) dig[i] <= '0;
    end else begin
      // A capture on the same edge as the load keeps pend set; the load used the old snap.
      if (chg0) begin
        snap0 <= out_port0;
        pend0 <= 1'b1;
      end else if (load && !pick) begin
        pend0 <= 1'b0;
      end
      if (chg1) begin
        snap1 <= out_port1;
        pend1 <= 1'b1;
      end else if (load && pick) begin
        pend1 <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (load) begin
            sel <= pick;
            bin <= (load_src > SAT_W) ? SAT_BIN : load_src[9:0];
            bcd <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          bcd <= shifted[21:10];
          bin <= shifted[9:0];
          cnt <= cnt + 4'd1;
        end
        DONE: begin
          if (sel) begin
            dig[3] <= bcd[3:0];
            dig[4] <= bcd[7:4];
            dig[5] <= bcd[11:8];
          end else begin
            dig[0] <= bcd[3:0];
            dig[1] <= bcd[7:4];
            dig[2] <= bcd[11:8];
          end
          last <= sel;
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return blank ? 7'b1111111 : s;
  endfunction

  logic blank_h0, blank_t0, blank_h1, blank_t1;

  always_comb begin
    blank_h0 = BLANK_LEAD && (dig[2] == 4'd0);
    blank_t0 = blank_h0 && (dig[1] == 4'd0);
    blank_h1 = BLANK_LEAD && (dig[5] == 4'd0);
    blank_t1 = blank_h1 && (dig[4] == 4'd0);
  end

  assign hex0 = seg(dig[0], 1'b0);
  assign hex1 = seg(dig[1], blank_t0);
  assign hex2 = seg(dig[2], blank_h0);
  assign hex3 = seg(dig[3], 1'b0);
  assign hex4 = seg(dig[4], blank_t1);
  assign hex5 = seg(dig[5], blank_h1);
  assign busy = (state != IDLE);

endmodule

// File: doc/sc_io_bcd_display.md
SC_IO_BCD_DISPLAY -- requirements
Module: sc_io_bcd_display

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SAT_MAX, 999, saturation ceiling applied to each channel value before conversion.
- BLANK_LEAD, 1, 1 = blank leading-zero hundreds/tens digits; 0 = show all digits.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1, single system clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high.
- out_port0, in, 32, channel 0 value from the data-memory I/O output port.
- out_port1, in, 32, channel 1 value from the data-memory I/O output port.
- hex0..hex2, out, 7 each, channel 0 units/tens/hundreds segments; active-low, bit6..bit0 = g..a.
- hex3..hex5, out, 7 each, channel 1 units/tens/hundreds segments; same encoding.
- busy, out, 1, high while a conversion is in progress.

Function
REQ-003 Change capture, per channel c, at every edge: if out_port<c> != snap<c>, then snap<c> <= out_port<c> and pend<c> <= 1.
REQ-004 Set wins: if capture and load of the same channel occur on the same edge, pend stays 1; the load uses the pre-edge snap.
REQ-005 FSM states are IDLE, SHIFT and DONE.
REQ-006 IDLE with no pend: remain in IDLE.
REQ-007 IDLE with pend set: choose a channel, load it, clear its pend, set cnt=0 and go to SHIFT.
- If only one pend is set, choose that channel.
- If both are set, choose the channel not served last.
REQ-008 Load: bin(10b) = (snap > SAT_MAX) ? SAT_MAX : snap[9:0], using an unsigned 32-bit compare; bcd(12b) = 0.
REQ-009 SHIFT, each cycle:
- add 3 to every bcd nibble >= 5;
- then shift {bcd,bin} left by 1;
- cnt increments;
- after the 10th shift (cnt==9), go to DONE.
REQ-010 DONE, one cycle: write bcd nibbles into the selected channel's digit registers (units, tens, hundreds), record last-served channel, go to IDLE.
REQ-011 Latency: a new value captured at edge E is visible on hex outputs after edge E+12 when the FSM is idle at E.
REQ-012 Back-to-back conversions: the second channel's digits update 12 edges after the first channel's.
REQ-013 busy = (state != IDLE); it is high for exactly 11 cycles per conversion.
REQ-014 Segment decode is combinational from the digit registers:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000;
- blank=1111111.
REQ-015 Leading blanking with BLANK_LEAD=1:
- hundreds is blank if 0;
- tens is blank if hundreds==0 and tens==0;
- units are never blank.
REQ-016 A value change during a conversion does not disturb that conversion; the new value converts afterwards, so the last value always wins.
REQ-017 Digit registers of the channel not being written hold their value.

Reset
REQ-018 On reset, at the edge:
- state=IDLE, cnt=0, pend0=pend1=0;
- snap0=snap1=0, all digit registers=0;
- last-served=channel 1, so channel 0 goes first on a tie.
REQ-019 Output values after reset:
- hex0=hex3=1000000;
- hex1,hex2,hex4,hex5=1111111 (BLANK_LEAD=1);
- busy=0.
REQ-020 Reset asserted mid-conversion aborts it on that edge and produces the REQ-018 state; no digit write occurs.

Verification
REQ-021 Reset with ports=0, held 20 cycles -> hex0=hex3=1000000, others 1111111, busy=0 throughout.
REQ-022 out_port0=123 sampled at edge E -> busy 1 for edges E+1..E+11; after E+12, hex2=1111001, hex1=0100100, hex0=0110000.
REQ-023 out_port1=1000 -> saturated to 999; hex5=hex4=hex3=0010000; out_port1=32'hFFFFFFFF gives the same result.
REQ-024 out_port0=5 and out_port1=7 captured on the same edge E:
- after E+12, hex0=0010010;
- after E+24, hex3=1111000;
- busy drops for exactly one cycle between the two conversions.
REQ-025 out_port0=100, then 42 applied 5 cycles into its conversion:
- 100 is displayed first;
- 12 edges after that, the display shows hex1=0011001, hex0=0100100, hex2 blank.
REQ-026 Reset asserted at the 6th SHIFT cycle of converting 555 -> outputs equal REQ-019 values; no 555 is ever displayed.
